// File: rtl/seg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_ctrl_pkg
// Shared types and constants for the two-digit counter/scan display controller.
//   scan_state_t  : display scan sequence states
//   AN_*          : active-low digit-enable patterns (an[0] = ones, an[1] = tens)
//   COUNT_W       : width of the count value
//   SEG_CODE_ZERO : sevenseg encoding of digit 0, used as the reset value of
//                   the registered segment bus
// -----------------------------------------------------------------------------
package seg_ctrl_pkg;

   typedef enum logic [1:0] {
      SHOW_ONES = 2'd0,
      BLANK_A   = 2'd1,
      SHOW_TENS = 2'd2,
      BLANK_B   = 2'd3
   } scan_state_t;

   localparam logic [1:0] AN_OFF  = 2'b11;
   localparam logic [1:0] AN_ONES = 2'b10;
   localparam logic [1:0] AN_TENS = 2'b01;

   localparam int COUNT_W = 6;

   // Must match the sevenseg table for digit 0 (segments a..f lit).
   localparam logic [6:0] SEG_CODE_ZERO = 7'h3F;

endpackage

// File: rtl/sevenseg.sv
// -----------------------------------------------------------------------------
// sevenseg
// Combinational BCD digit to 7-segment encoder, active-high segments,
// seg[0] = a ... seg[6] = g. Non-decimal inputs produce a dark digit.
//   digit : 4-bit digit value
//   seg   : segment pattern
// -----------------------------------------------------------------------------
module sevenseg (
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h00;
      case (digit)
         4'd0: seg = 7'h3F;
         4'd1: seg = 7'h06;
         4'd2: seg = 7'h5B;
         4'd3: seg = 7'h4F;
         4'd4: seg = 7'h66;
         4'd5: seg = 7'h6D;
         4'd6: seg = 7'h7D;
         4'd7: seg = 7'h07;
         4'd8: seg = 7'h7F;
         4'd9: seg = 7'h6F;
         default: seg = 7'h00;
      endcase
   end

endmodule

// File: rtl/sevenseg2.sv
// -----------------------------------------------------------------------------
// sevenseg2
// Splits a 0..63 value into ones and tens digits and encodes each through a
// sevenseg instance.
//   value    : binary value (tens digit is 0..6)
//   seg_ones : sevenseg code of value % 10
//   seg_tens : sevenseg code of value / 10
// -----------------------------------------------------------------------------
module sevenseg2 (
   input  logic [5:0] value,
   output logic [6:0] seg_ones,
   output logic [6:0] seg_tens
);

   logic [3:0] digit [2];
   logic [6:0] code  [2];

   assign digit[0] = 4'(value % 6'd10);
   assign digit[1] = 4'(value / 6'd10);

   for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      sevenseg u_enc (
         .digit (digit[gi]),
         .seg   (code[gi])
      );
   end

   assign seg_ones = code[0];
   assign seg_tens = code[1];

endmodule

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler: counts 0..PRESCALE-1 while enabled, holds while disabled.
// tick is high for the cycle the prescaler sits at PRESCALE-1 with enable=1.
//   clk    : system clock
//   reset  : synchronous active-high reset (prescaler -> 0)
//   enable : run the prescaler
//   clear  : restart the prescaler from 0 (used by count load)
//   tick   : one-cycle count tick
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int PRESCALE = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int PSC_W = $clog2(PRESCALE);
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

   logic [PSC_W-1:0] psc_reg;
   logic [PSC_W-1:0] psc_next;

   assign tick = enable && (psc_reg == PSC_LAST);

   always_comb begin
      psc_next = psc_reg;
      if (clear) begin
         psc_next = '0;
      end else if (enable) begin
         psc_next = tick ? '0 : psc_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         psc_reg <= '0;
      end else begin
         psc_reg <= psc_next;
      end
   end

endmodule

// File: rtl/seg_count_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_count_scan_ctrl
// 0..MAX_COUNT up/down counter driven by a prescaled tick, shown on a
// two-digit multiplexed 7-segment display through one shared segment bus.
//   clk        : system clock
//   reset      : synchronous active-high reset
//   enable     : 1 = prescaler runs, 0 = count frozen (scan keeps running)
//   up         : count direction, sampled at each tick
//   load       : single-cycle load strobe (wins over a simultaneous tick)
//   load_value : value to load, clamped to MAX_COUNT
//   count      : current count
//   wrap       : one-cycle pulse on wrap-around
//   seg        : registered segment bus (sevenseg encoding)
//   an         : active-low digit enables, an[0] = ones, an[1] = tens
// Build option: define LEADING_ZERO_BLANK_EN to keep the tens digit dark
// while count < 10.
// -----------------------------------------------------------------------------
module seg_count_scan_ctrl
   import seg_ctrl_pkg::*;
#(
   parameter int PRESCALE  = 50_000_000,
   parameter int SCAN_DIV  = 50_000,
   parameter int BLANK_CYC = 500,
   parameter int MAX_COUNT = 59
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               up,
   input  logic               load,
   input  logic [COUNT_W-1:0] load_value,
   output logic [COUNT_W-1:0] count,
   output logic               wrap,
   output logic [6:0]         seg,
   output logic [1:0]         an
);

   localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);
   localparam int SLOT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int SLOT_W   = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
   localparam logic [SLOT_W-1:0] SCAN_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);

   logic               tick;
   logic [COUNT_W-1:0] count_reg, count_next;
   logic               wrap_reg, wrap_next;
   scan_state_t        state_reg, state_next;
   logic [SLOT_W-1:0]  slot_reg, slot_next;
   logic [1:0]         an_reg, an_next;
   logic [6:0]         seg_reg, seg_next;
   logic [6:0]         seg_ones, seg_tens;

   // Load restarts the prescaler so the next change is a full period away.
   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (load),
      .tick   (tick)
   );

   sevenseg2 u_digits (
      .value    (count_reg),
      .seg_ones (seg_ones),
      .seg_tens (seg_tens)
   );

   // ---------------------------------------------------------------- counter
   always_comb begin
      count_next = count_reg;
      wrap_next  = 1'b0;
      if (load) begin
         count_next = (load_value > MAX_C) ? MAX_C : load_value;
      end else if (tick) begin
         if (up) begin
            if (count_reg == MAX_C) begin
               count_next = '0;
               wrap_next  = 1'b1;
            end else begin
               count_next = count_reg + 1'b1;
            end
         end else begin
            if (count_reg == '0) begin
               count_next = MAX_C;
               wrap_next  = 1'b1;
            end else begin
               count_next = count_reg - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
         wrap_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         wrap_reg  <= wrap_next;
      end
   end

   // --------------------------------------------------------------- scan FSM
   // Outputs are decoded from the state being entered so an/seg change on the
   // same edge as the state. In SHOW slots seg follows count every cycle,
   // giving exactly one cycle of latency after a count update.
   always_comb begin
      state_next = state_reg;
      slot_next  = slot_reg + 1'b1;
      an_next    = an_reg;
      seg_next   = seg_reg;

      case (state_reg)
         SHOW_ONES: if (slot_reg == SCAN_LAST) begin
            state_next = BLANK_A;
            slot_next  = '0;
         end
         BLANK_A: if (slot_reg == BLANK_LAST) begin
            state_next = SHOW_TENS;
            slot_next  = '0;
         end
         SHOW_TENS: if (slot_reg == SCAN_LAST) begin
            state_next = BLANK_B;
            slot_next  = '0;
         end
         BLANK_B: if (slot_reg == BLANK_LAST) begin
            state_next = SHOW_ONES;
            slot_next  = '0;
         end
         default: begin
            state_next = SHOW_ONES;
            slot_next  = '0;
         end
      endcase

      case (state_next)
         SHOW_ONES: begin
            an_next  = AN_ONES;
            seg_next = seg_ones;
         end
         SHOW_TENS: begin
            an_next  = AN_TENS;
            seg_next = seg_tens;
`ifdef LEADING_ZERO_BLANK_EN
            if (count_reg < COUNT_W'(10)) begin
               an_next = AN_OFF;
            end
`endif
         end
         default: begin
            an_next = AN_OFF;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= SHOW_ONES;
         slot_reg  <= '0;
         an_reg    <= AN_ONES;
         seg_reg   <= SEG_CODE_ZERO;
      end else begin
         state_reg <= state_next;
         slot_reg  <= slot_next;
         an_reg    <= an_next;
         seg_reg   <= seg_next;
      end
   end

   assign count = count_reg;
   assign wrap  = wrap_reg;
   assign seg   = seg_reg;
   assign an    = an_reg;

endmodule

// File: tb/tb_seg_count_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_count_scan_ctrl
// Directed vector table, hand-written multi-cycle sequences and randomized
// traffic for seg_count_scan_ctrl, all checked against a cycle-level model
// built from the counting and display-scan rules.
// -----------------------------------------------------------------------------
module tb_seg_count_scan_ctrl;

   localparam int P      = 4;
   localparam int SD     = 3;
   localparam int BC     = 1;
   localparam int MAXC   = 59;
   localparam int PERIOD = 2 * (SD + BC);
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1, enable = 1'b0, up = 1'b1, load = 1'b0;
   logic [5:0] load_value = '0;
   logic [5:0] count;
   logic       wrap;
   logic [6:0] seg;
   logic [1:0] an;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   seg_count_scan_ctrl #(
      .PRESCALE  (P),
      .SCAN_DIV  (SD),
      .BLANK_CYC (BC),
      .MAX_COUNT (MAXC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .up         (up),
      .load       (load),
      .load_value (load_value),
      .count      (count),
      .wrap       (wrap),
      .seg        (seg),
      .an         (an)
   );

   function automatic logic [6:0] code(input int d);
      case (d)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         7: return 7'h07;
         8: return 7'h7F;
         9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // ------------------------------------------------------------ ref model
   int         m_count = 0;
   int         m_psc = 0;
   int         m_pos = 0;      // cycle position within the scan period
   logic       m_wrap = 1'b0;
   logic [1:0] m_an = 2'b10;
   logic [6:0] m_seg = 7'h3F;

   task automatic model_edge(input logic r, e, u, l, input logic [5:0] lv);
      int  c0;
      bit  tk;
      c0 = m_count;
      tk = e && (m_psc == P - 1);
      if (r) begin
         m_count = 0; m_psc = 0; m_wrap = 1'b0; m_pos = 0;
         m_an = 2'b10; m_seg = code(0);
         return;
      end
      m_pos = (m_pos + 1) % PERIOD;
      if (m_pos < SD) begin
         m_an = 2'b10; m_seg = code(c0 % 10);
      end else if (m_pos < SD + BC) begin
         m_an = 2'b11;
      end else if (m_pos < 2 * SD + BC) begin
         m_an = (LZB && c0 < 10) ? 2'b11 : 2'b01;
         m_seg = code(c0 / 10);
      end else begin
         m_an = 2'b11;
      end
      m_wrap = 1'b0;
      if (l) begin
         m_count = (int'(lv) > MAXC) ? MAXC : int'(lv);
         m_psc = 0;
      end else begin
         if (e) m_psc = tk ? 0 : m_psc + 1;
         if (tk) begin
            if (u) begin
               if (c0 == MAXC) begin m_count = 0; m_wrap = 1'b1; end
               else m_count = c0 + 1;
            end else begin
               if (c0 == 0) begin m_count = MAXC; m_wrap = 1'b1; end
               else m_count = c0 - 1;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // One clock: drive inputs, advance the model, compare all outputs.
   task automatic step(input logic r, e, u, l, input logic [5:0] lv);
      reset = r; enable = e; up = u; load = l; load_value = lv;
      @(posedge clk);
      model_edge(r, e, u, l, lv);
      #1;
      check("count", 8'(count), 8'(m_count));
      check("wrap",  8'(wrap),  8'(m_wrap));
      check("an",    8'(an),    8'(m_an));
      check("seg",   8'(seg),   8'(m_seg));
   endtask

   // ------------------------------------------------------------ vectors
   typedef struct {
      logic r, e, u, l;
      logic [5:0] lv;
      logic [5:0] ec;
      logic       ew;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, e, u, l, input logic [5:0] lv,
                      input logic [5:0] ec, input logic ew, input int n);
      vec_t v;
      v.r = r; v.e = e; v.u = u; v.l = l; v.lv = lv; v.ec = ec; v.ew = ew;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   logic [1:0] pat [8];

   initial begin
      // reset, then wrap up from 58
      add(1, 0, 1, 0, 6'd0,  6'd0,  0, 1);
      add(0, 1, 1, 1, 6'd58, 6'd58, 0, 1);
      add(0, 1, 1, 0, 6'd0,  6'd58, 0, 3);
      add(0, 1, 1, 0, 6'd0,  6'd59, 0, 4);
      add(0, 1, 1, 0, 6'd0,  6'd0,  1, 1);
      add(0, 1, 1, 0, 6'd0,  6'd0,  0, 1);
      // wrap down from 0
      add(0, 1, 0, 1, 6'd0,  6'd0,  0, 1);
      add(0, 1, 0, 0, 6'd0,  6'd0,  0, 3);
      add(0, 1, 0, 0, 6'd0,  6'd59, 1, 1);
      add(0, 1, 0, 0, 6'd0,  6'd59, 0, 3);
      add(0, 1, 0, 0, 6'd0,  6'd58, 0, 1);
      // load clamp, then load on a tick cycle
      add(0, 1, 0, 1, 6'd63, 6'd59, 0, 1);
      add(0, 1, 0, 0, 6'd0,  6'd59, 0, 3);
      add(0, 1, 0, 1, 6'd12, 6'd12, 0, 1);
      add(0, 1, 0, 0, 6'd0,  6'd12, 0, 3);
      add(0, 1, 0, 0, 6'd0,  6'd11, 0, 1);

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].lv);
         check($sformatf("vec%0d_count", i), 8'(count), 8'(tbl[i].ec));
         check($sformatf("vec%0d_wrap", i),  8'(wrap),  8'(tbl[i].ew));
      end
      $display("directed vectors: %0d applied", tbl.size());

      // reset mid-run at 37
      step(0, 0, 1, 1, 6'd37);
      for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 6'd0);
      check("pre_reset_count", 8'(count), 8'd37);
      step(1, 1, 1, 0, 6'd0);
      check("rst_count", 8'(count), 8'd0);
      check("rst_wrap",  8'(wrap),  8'd0);
      check("rst_an",    8'(an),    8'(2'b10));
      check("rst_seg",   8'(seg),   8'(code(0)));
      $display("mid-run reset sequence done");

      // scan sequence, count 47, enable=0 so count stays frozen
      pat = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};
      step(1, 0, 1, 0, 6'd0);
      step(0, 0, 1, 1, 6'd47);
      for (int k = 0; k < 16; k++) begin
         int pos;
         step(0, 0, 1, 0, 6'd0);
         pos = (k + 2) % PERIOD;
         if (k >= 6) begin
            check("scan_an", 8'(an), 8'(pat[pos]));
            check("scan_frozen", 8'(count), 8'd47);
            if (pos < 3)               check("scan_seg_ones", 8'(seg), 8'(code(7)));
            else if (pos >= 4 && pos < 7) check("scan_seg_tens", 8'(seg), 8'(code(4)));
         end
      end
      $display("scan sequence at 47 done");

      // tens digit with count < 10
      step(1, 0, 1, 0, 6'd0);
      step(0, 0, 1, 1, 6'd5);
      for (int k = 0; k < 16; k++) begin
         int pos;
         step(0, 0, 1, 0, 6'd0);
         pos = (k + 2) % PERIOD;
         if (k >= 6 && pos >= 4 && pos < 7) begin
            if (LZB) begin
               check("lzb_an", 8'(an), 8'(2'b11));
            end else begin
               check("tens0_an",  8'(an),  8'(2'b01));
               check("tens0_seg", 8'(seg), 8'(code(0)));
            end
         end
      end
      $display("leading-zero sequence done");

      // randomized traffic
      step(1, 0, 1, 0, 6'd0);
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0,
              6'($urandom_range(0, 63)));
      end
      $display("random traffic: 3000 cycles");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
